// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/control FSM for the 8-bit accumulator datapath
module instr_sequencer #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [PC_W-1:0] imem_addr,
   input  logic [8:0]      imem_data,
   output logic            type_code,
   output logic [3:0]      r_op,
   output logic [2:0]      i_op,
   output logic [4:0]      imm,
   output logic [3:0]      reg_sel,
   input  logic [7:0]      op_val,
   output logic            sc_in,
   input  logic            sc_out,
   input  logic            branch,
   output logic            acc_we,
   output logic            acc_src,
   output logic            reg_we,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   output logic [PC_W-1:0] pc,
   output logic            done
);
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, HALT} stateT;
   stateT state, nextState;
   logic [8:0] ir;
   logic [PC_W-1:0] pcReg;
   logic scReg;
   logic isLw, isSw, isSet, isHalt, accWrite, scUpdate, takeJump;
   assign type_code = ir[8];
   assign r_op = ir[7:4];
   assign i_op = ir[7:5];
   assign imm = ir[4:0];
   assign reg_sel = ir[3:0];
   assign imem_addr = pcReg;
   assign pc = pcReg;
   assign sc_in = scReg;
   assign isLw = !ir[8] && ir[7:4] == 4'b1000;
   assign isSw = !ir[8] && ir[7:4] == 4'b1001;
   assign isSet = !ir[8] && ir[7:4] == 4'b1110;
   assign isHalt = ir[8] && ir[7:5] == 3'b111;
   assign accWrite = ir[8] ? (ir[7:5] <= 3'd5)
                           : (ir[7:4] <= 4'd8 || ir[7:4] == 4'd10 || ir[7:4] == 4'd11 || ir[7:4] == 4'd15);
   assign scUpdate = ir[8] ? (ir[7:6] == 2'b00) : (ir[7:5] == 3'b000);
   assign takeJump = !ir[8] && (ir[7:4] == 4'b1101 || (ir[7:4] == 4'b1100 && branch));
   always_comb begin
      nextState = state;
      acc_we = 1'b0;
      acc_src = 1'b0;
      reg_we = 1'b0;
      dmem_req = 1'b0;
      dmem_we = 1'b0;
      done = state == HALT;
      case (state)
         IDLE, HALT: nextState = start ? FETCH : state;
         FETCH: nextState = EXEC;
         EXEC: nextState = (isLw || isSw) ? MEM : isHalt ? HALT : WB;
         MEM: begin
            dmem_req = 1'b1;
            dmem_we = isSw;
            nextState = dmem_ack ? WB : MEM;
         end
         WB: begin
            acc_we = accWrite;
            acc_src = isLw;
            reg_we = isSet;
            nextState = FETCH;
         end
         default: nextState = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nextState;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcReg <= '0;
         scReg <= 1'b0;
         ir <= '0;
      end else begin
         if ((state == IDLE || state == HALT) && start) begin
            pcReg <= '0;
            scReg <= 1'b0;
         end
         if (state == FETCH) ir <= imem_data;
         if (state == WB) begin
            pcReg <= takeJump ? PC_W'(op_val) : pcReg + PC_W'(1);
            if (scUpdate) scReg <= sc_out;
         end
      end
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed programs; stimulus queues expected strobe/halt events, a monitor scores them
module tb_instr_sequencer;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [7:0] imem_addr, pc, op_val;
   logic [8:0] imem_data;
   logic type_code, sc_in, sc_out, branch, acc_we, acc_src, reg_we, dmem_req, dmem_we, dmem_ack, done;
   logic [3:0] r_op, reg_sel;
   logic [2:0] i_op;
   logic [4:0] imm;
   logic [8:0] rom [256];
   logic [7:0] regs [16];
   logic branchVal = 1'b0;
   int ackDelay = 1, memCnt = 0;
   int checks = 0, fails = 0;
   logic [31:0] expQ [$];
   logic doneQ = 1'b0;

   instr_sequencer #(.PC_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
      .type_code(type_code), .r_op(r_op), .i_op(i_op), .imm(imm), .reg_sel(reg_sel),
      .op_val(op_val), .sc_in(sc_in), .sc_out(sc_out), .branch(branch), .acc_we(acc_we),
      .acc_src(acc_src), .reg_we(reg_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_ack(dmem_ack), .pc(pc), .done(done)
   );

   always #5 clk = ~clk;
   assign imem_data = rom[imem_addr];
   assign op_val = regs[reg_sel];
   assign branch = branchVal;
   // carry out is asserted only while an R-type ADD is decoded
   assign sc_out = !type_code && r_op == 4'b0000;

   // flags: acc_we acc_src reg_we dmem_req dmem_we done sc_in
   function automatic logic [31:0] mk(input logic [6:0] f, input logic [7:0] p, input logic [8:0] i);
      return {f, p, i, i[7:0]};
   endfunction

   initial begin
      dmem_ack = 1'b0;
      forever begin
         @(negedge clk);
         memCnt = dmem_req ? memCnt + 1 : 0;
         dmem_ack = dmem_req && memCnt == ackDelay;
      end
   end

   initial begin
      logic [31:0] act, want;
      forever begin
         @(negedge clk);
         if (rst_n && (acc_we || reg_we || dmem_req || (done && !doneQ))) begin
            act = {acc_we, acc_src, reg_we, dmem_req, dmem_we, done, sc_in, pc,
                   type_code, r_op, reg_sel, i_op, imm};
            checks++;
            if (expQ.size() == 0) begin
               fails++;
               $display("FAIL event: unexpected output %h, required none", act);
            end else begin
               want = expQ.pop_front();
               if (act !== want) begin
                  fails++;
                  $display("FAIL event: got %h, required %h", act, want);
               end
            end
         end
         doneQ = done;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, want);
      end
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      check("reset", {8'h0, pc, sc_in, done, acc_we, acc_src, reg_we, dmem_req, dmem_we,
                      type_code, r_op, reg_sel}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic clearMem();
      for (int i = 0; i < 256; i++) rom[i] = 9'h1E0;
      for (int i = 0; i < 16; i++) regs[i] = 8'h00;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic waitQ(input string name);
      int n = 0;
      while (expQ.size() != 0 && n < 300) begin
         @(posedge clk);
         #1 n++;
      end
      if (expQ.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL %s: timeout with %0d events outstanding, required 0", name, expQ.size());
         expQ.delete();
      end
   endtask

   initial begin
      int n;
      // ADDI then HALT
      clearMem();
      doReset();
      rom[0] = 9'h105;
      expQ.push_back(mk(7'b1000000, 8'h00, 9'h105));
      expQ.push_back(mk(7'b0000010, 8'h01, 9'h1E0));
      pulseStart();
      waitQ("addi");
      repeat (3) @(posedge clk);
      #1 check("haltHold", {done, pc}, {1'b1, 8'h01});
      // ADD sets carry, AND keeps it; start mid-instruction ignored
      clearMem();
      doReset();
      rom[0] = 9'h003;
      rom[1] = 9'h023;
      expQ.push_back(mk(7'b1000000, 8'h00, 9'h003));
      expQ.push_back(mk(7'b1000001, 8'h01, 9'h023));
      expQ.push_back(mk(7'b0000011, 8'h02, 9'h1E0));
      pulseStart();
      repeat (3) @(posedge clk);
      #1 pulseStart();
      waitQ("addAnd");
      // BR taken / not taken
      clearMem();
      doReset();
      rom[0] = 9'h0C2;
      regs[2] = 8'h10;
      branchVal = 1'b1;
      expQ.push_back(mk(7'b0000010, 8'h10, 9'h1E0));
      pulseStart();
      waitQ("brTaken");
      doReset();
      branchVal = 1'b0;
      expQ.push_back(mk(7'b0000010, 8'h01, 9'h1E0));
      pulseStart();
      waitQ("brNot");
      // SET then J
      clearMem();
      doReset();
      rom[0] = 9'h0E5;
      rom[1] = 9'h0D3;
      regs[3] = 8'h07;
      expQ.push_back(mk(7'b0010000, 8'h00, 9'h0E5));
      expQ.push_back(mk(7'b0000010, 8'h07, 9'h1E0));
      pulseStart();
      waitQ("setJump");
      // LW with three MEM cycles
      clearMem();
      doReset();
      rom[0] = 9'h081;
      regs[1] = 8'h20;
      ackDelay = 3;
      repeat (3) expQ.push_back(mk(7'b0001000, 8'h00, 9'h081));
      expQ.push_back(mk(7'b1100000, 8'h00, 9'h081));
      expQ.push_back(mk(7'b0000010, 8'h01, 9'h1E0));
      pulseStart();
      waitQ("load");
      // SW
      clearMem();
      doReset();
      rom[0] = 9'h091;
      regs[1] = 8'h20;
      ackDelay = 1;
      expQ.push_back(mk(7'b0001100, 8'h00, 9'h091));
      expQ.push_back(mk(7'b0000010, 8'h01, 9'h1E0));
      pulseStart();
      waitQ("store");
      // reset in the middle of a load that is never acknowledged
      clearMem();
      doReset();
      rom[0] = 9'h003;
      rom[1] = 9'h081;
      regs[1] = 8'h20;
      ackDelay = 100;
      expQ.push_back(mk(7'b1000000, 8'h00, 9'h003));
      repeat (2) expQ.push_back(mk(7'b0001001, 8'h01, 9'h081));
      pulseStart();
      n = 0;
      while (!dmem_req && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      check("memEntry", {31'h0, dmem_req}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check("rstMem", {15'h0, dmem_req, acc_we, done, sc_in, pc}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 check("rstIdle", {22'h0, dmem_req, done, pc}, 32'h0);
      check("rstQueue", expQ.size(), 32'h0);
      expQ.delete();
      ackDelay = 1;
      // pc wrap: J to 0xFF, NOP there, then ROM[0] becomes HALT
      clearMem();
      doReset();
      rom[0] = 9'h0D3;
      regs[3] = 8'hFF;
      rom[8'hFF] = 9'h1C0;
      expQ.push_back(mk(7'b0000010, 8'h00, 9'h1E0));
      pulseStart();
      n = 0;
      while (pc != 8'hFF && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      check("pcFF", {24'h0, pc}, 32'hFF);
      rom[0] = 9'h1E0;
      waitQ("wrap");
      repeat (3) @(posedge clk);
      #1 check("endQueue", expQ.size(), 32'h0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
